fwd_hazard_ctrl: RTL and testbench
==================================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Forwarding and hazard scheduler for the 5-stage pipelined CPU. Drives the 2-bit selects of the two
//  EX-stage operand 3-to-1 forwarding muxes and the pipeline stall/flush controls.
//  Keeps its own shadow copy of the ID/EX, EX/MEM and MEM/WB register-tag fields, so it needs only
//  decode-stage tags plus branch resolution from EX.
// PARAMETERS
//  REG_W    5   register-index width
//  CNT_W    16  width of the statistics counters (FWD_HAZ_STATS_EN only)
// PORTS
//  clk_i           in   1      system clock, rising edge
//  rst_i           in   1      asynchronous reset, active-low
//  id_rs_i         in   REG_W  rs of instruction in ID
//  id_rt_i         in   REG_W  rt of instruction in ID
//  id_rd_i         in   REG_W  destination of instruction in ID, after RegDst selection
//  id_regwrite_i   in   1      ID instruction writes the register file
//  id_memread_i    in   1      ID instruction is a load
//  ex_branch_tkn_i in   1      branch in EX resolved taken this cycle
//  fwd_a_sel_o     out  2      select for EX operand-A mux: 00 RF/ID-EX, 01 MEM/WB result, 10 EX/MEM result
//  fwd_b_sel_o     out  2      same encoding, operand B
//  pc_write_o      out  1      1 = PC may update
//  ifid_write_o    out  1      1 = IF/ID may load
//  ifid_flush_o    out  1      1 = IF/ID loads a bubble
//  idex_flush_o    out  1      1 = ID/EX loads a bubble
//  stall_cnt_o     out  CNT_W  load-use stall cycles (FWD_HAZ_STATS_EN only)
//  flush_cnt_o     out  CNT_W  taken-branch flushes (FWD_HAZ_STATS_EN only)
// BEHAVIOUR
//  - Reset (rst_i=0, async): all shadow stages cleared (regwrite=0, memread=0, tags=0).
//    FSM=RUN. fwd_*_sel_o=00. pc_write_o=1, ifid_write_o=1, both flushes=0. Counters=0.
//  - Shadow pipe, each rising edge: MEM/WB<=EX/MEM, EX/MEM<=ID/EX.
//    ID/EX<=ID tags, or a bubble (regwrite=0, memread=0) when idex_flush_o=1.
//  - Forward select, combinational from shadow state, 0-cycle latency. For operand A (rs), same for B (rt):
//    10 if EX/MEM.regwrite & EX/MEM.rd!=0 & EX/MEM.rd==ID/EX.rs;
//    else 01 if MEM/WB.regwrite & MEM/WB.rd!=0 & MEM/WB.rd==ID/EX.rs; else 00.
//    EX/MEM has priority. 11 is never driven. $0 is never forwarded.
//  - RF writes on negedge, so WB->ID needs no forwarding.
//  - Load-use hazard: ID/EX.memread & ID/EX.rd!=0 & (ID/EX.rd==id_rs_i | ID/EX.rd==id_rt_i).
//  - FSM (registered state; outputs decoded combinationally from state + hazard inputs):
//    RUN:   taken -> idex_flush=1, ifid_flush=1 -> FLUSH.
//           else load-use -> pc_write=0, ifid_write=0, idex_flush=1 -> STALL.
//           else normal.
//    STALL: exactly one bubble cycle done. Re-evaluate as RUN: a second load-use is impossible
//           because ID/EX now holds a bubble. -> RUN.
//    FLUSH: normal controls -> RUN. A taken branch in FLUSH is impossible; if seen, treat as RUN.
//  - Simultaneous taken branch + load-use: branch wins. No stall. Stall counter not incremented.
//  - Reset mid-stall/flush: aborts immediately to RUN, controls return to reset values.
// CONFIGURATION
//  FWD_HAZ_STATS_EN defined:
//    stall_cnt_o +1 per cycle with load-use stall asserted; flush_cnt_o +1 per taken flush.
//    Both saturate at all-ones.
//  Undefined: both counters and their ports are absent.
// STRUCTURE
//  fwd_hazard_defs.vh (`include):
//    FWD_SEL_RF=2'b00, FWD_SEL_WB=2'b01, FWD_SEL_MEM=2'b10.
//    FSM encodings ST_RUN/ST_STALL/ST_FLUSH.
//  Sub-module fwd_sel_unit: combinational priority compare for one operand, instanced twice (A, B).
//  FSM, shadow pipe and counters stay in the top module.
// TESTING
//  1. add $3 then add uses $3 as rs -> next cycle fwd_a_sel_o=10, fwd_b_sel_o=00, no stall.
//  2. Dependent instruction two slots later -> fwd_a_sel_o=01. Dependency on both slots -> 10 (priority).
//  3. lw $4 followed by use of $4 as rt -> one cycle of pc_write_o=0, ifid_write_o=0, idex_flush_o=1.
//     Then fwd_b_sel_o=01 on the consumer.
//  4. Writer targets $0 followed by reader of $0 -> selects stay 00.
//     lw $0 followed by use of $0 -> no stall.
//  5. ex_branch_tkn_i=1 with a load-use pending -> ifid_flush_o=1, idex_flush_o=1, pc_write_o=1.
//     No stall. flush_cnt_o=1, stall_cnt_o=0.
//  6. rst_i low during STALL -> outputs immediately at reset values. Selects 00 after release.
//     With CNT_W=2 and 5 stalls -> stall_cnt_o=3 (saturated).

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared constants for the forwarding / hazard scheduler: forward-mux
// select codes, scheduler state encodings and the pipeline-control bundle.
package fwd_hazard_ctrl_pkg;

    // EX operand mux select codes (11 is never driven)
    localparam logic [1:0] FWD_SEL_RF  = 2'b00;
    localparam logic [1:0] FWD_SEL_WB  = 2'b01;
    localparam logic [1:0] FWD_SEL_MEM = 2'b10;

    // Scheduler state encodings
    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;

    // Pipeline control bundle driven towards PC, IF/ID and ID/EX
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
    } hz_ctrl_t;

    // Free-running pipeline: everything advances, nothing is squashed
    localparam hz_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1,
                                         ifid_flush: 1'b0, idex_flush: 1'b0};
    // Load-use stall: freeze PC and IF/ID, push a bubble into ID/EX
    localparam hz_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0,
                                         ifid_flush: 1'b0, idex_flush: 1'b1};
    // Taken branch: squash the two younger instructions, keep fetching
    localparam hz_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1,
                                         ifid_flush: 1'b1, idex_flush: 1'b1};

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_sel_unit.sv
// fwd_sel_unit: priority forwarding compare for a single EX operand.
// The younger producer (EX/MEM) wins over MEM/WB; register $0 is never
// forwarded because it is hard-wired to zero in the register file.
module fwd_sel_unit
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic             exmem_regwrite,
    input  logic [REG_W-1:0] memwb_rd,
    input  logic             memwb_regwrite,
    output logic [1:0]       sel
);

    logic exmem_hit_s;
    logic memwb_hit_s;

    assign exmem_hit_s = exmem_regwrite && (exmem_rd != {REG_W{1'b0}}) && (exmem_rd == src);
    assign memwb_hit_s = memwb_regwrite && (memwb_rd != {REG_W{1'b0}}) && (memwb_rd == src);

    // Pick the youngest matching producer, else the register-file value
    always_comb begin
        sel = FWD_SEL_RF;
        if (exmem_hit_s) begin
            sel = FWD_SEL_MEM;
        end else if (memwb_hit_s) begin
            sel = FWD_SEL_WB;
        end else begin
            sel = FWD_SEL_RF;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding and hazard scheduler for the 5-stage CPU.
// Keeps a shadow copy of the ID/EX, EX/MEM and MEM/WB tag fields, drives
// the two EX forwarding-mux selects and the stall/flush controls.
// Optional build macro FWD_HAZ_STATS_EN adds saturating stall/flush
// counters (parameter CNT_W and ports stall_cnt_o / flush_cnt_o).
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5
`ifdef FWD_HAZ_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             ex_branch_tkn_i,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o
`ifdef FWD_HAZ_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    // Shadow pipeline tag fields
    logic [REG_W-1:0] idex_rs_r;
    logic [REG_W-1:0] idex_rt_r;
    logic [REG_W-1:0] idex_rd_r;
    logic             idex_regwrite_r;
    logic             idex_memread_r;
    logic [REG_W-1:0] exmem_rd_r;
    logic             exmem_regwrite_r;
    logic [REG_W-1:0] memwb_rd_r;
    logic             memwb_regwrite_r;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             load_use_s;
    hz_ctrl_t         run_ctrl_s;
    logic [1:0]       run_nxt_s;
    hz_ctrl_t         ctrl_s;
    logic             stall_evt_s;
    logic             flush_evt_s;

    // Load in EX whose destination is read by the instruction in ID
    assign load_use_s = idex_memread_r && (idex_rd_r != {REG_W{1'b0}}) &&
                        ((idex_rd_r == id_rs_i) || (idex_rd_r == id_rt_i));

    fwd_sel_unit #(.REG_W(REG_W)) u_fwd_a (
        .src            (idex_rs_r),
        .exmem_rd       (exmem_rd_r),
        .exmem_regwrite (exmem_regwrite_r),
        .memwb_rd       (memwb_rd_r),
        .memwb_regwrite (memwb_regwrite_r),
        .sel            (fwd_a_sel_o)
    );

    fwd_sel_unit #(.REG_W(REG_W)) u_fwd_b (
        .src            (idex_rt_r),
        .exmem_rd       (exmem_rd_r),
        .exmem_regwrite (exmem_regwrite_r),
        .memwb_rd       (memwb_rd_r),
        .memwb_regwrite (memwb_regwrite_r),
        .sel            (fwd_b_sel_o)
    );

    // RUN-style evaluation: a taken branch beats a load-use stall
    always_comb begin
        run_ctrl_s = CTRL_NORMAL;
        run_nxt_s  = ST_RUN;
        if (ex_branch_tkn_i) begin
            run_ctrl_s = CTRL_FLUSH;
            run_nxt_s  = ST_FLUSH;
        end else if (load_use_s) begin
            run_ctrl_s = CTRL_STALL;
            run_nxt_s  = ST_STALL;
        end else begin
            run_ctrl_s = CTRL_NORMAL;
            run_nxt_s  = ST_RUN;
        end
    end

    // State decode: STALL and FLUSH leave a bubble in ID/EX, so a repeat
    // load-use cannot occur there and re-evaluating as RUN is exact; an
    // illegal encoding recovers to RUN with free-running controls
    always_comb begin
        ctrl_s      = CTRL_NORMAL;
        state_nxt_s = ST_RUN;
        case (state_r)
            ST_RUN, ST_STALL, ST_FLUSH: begin
                ctrl_s      = run_ctrl_s;
                state_nxt_s = run_nxt_s;
            end
            default: begin
                ctrl_s      = CTRL_NORMAL;
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    assign stall_evt_s = ctrl_s.idex_flush && !ctrl_s.ifid_flush;
    assign flush_evt_s = ctrl_s.ifid_flush;

    // Controls are forced to their reset values while reset is held so an
    // in-flight stall or flush is abandoned immediately
    assign pc_write_o   = rst_i ? ctrl_s.pc_write   : 1'b1;
    assign ifid_write_o = rst_i ? ctrl_s.ifid_write : 1'b1;
    assign ifid_flush_o = rst_i ? ctrl_s.ifid_flush : 1'b0;
    assign idex_flush_o = rst_i ? ctrl_s.idex_flush : 1'b0;

    // Scheduler state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Shadow pipe: tags advance every cycle, ID/EX takes a bubble on flush
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_rs_r        <= {REG_W{1'b0}};
            idex_rt_r        <= {REG_W{1'b0}};
            idex_rd_r        <= {REG_W{1'b0}};
            idex_regwrite_r  <= 1'b0;
            idex_memread_r   <= 1'b0;
            exmem_rd_r       <= {REG_W{1'b0}};
            exmem_regwrite_r <= 1'b0;
            memwb_rd_r       <= {REG_W{1'b0}};
            memwb_regwrite_r <= 1'b0;
        end else begin
            memwb_rd_r       <= exmem_rd_r;
            memwb_regwrite_r <= exmem_regwrite_r;
            exmem_rd_r       <= idex_rd_r;
            exmem_regwrite_r <= idex_regwrite_r;
            idex_rs_r        <= id_rs_i;
            idex_rt_r        <= id_rt_i;
            idex_rd_r        <= id_rd_i;
            idex_regwrite_r  <= id_regwrite_i && !ctrl_s.idex_flush;
            idex_memread_r   <= id_memread_i  && !ctrl_s.idex_flush;
        end
    end

`ifdef FWD_HAZ_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating statistics: load-use stall cycles and taken-branch flushes
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_evt_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_evt_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_r;
    assign flush_cnt_o = flush_cnt_r;
`else
    logic unused_evt_s;
    assign unused_evt_s = stall_evt_s ^ flush_evt_s;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed hazard scenarios
// followed by randomized instruction streams, all checked against an
// instruction-level model (a queue of in-flight instructions).
module tb_fwd_hazard_ctrl;

    localparam int REG_W = 5;
`ifdef FWD_HAZ_STATS_EN
    localparam int CNT_W = 2;
    localparam int CNT_SAT = (1 << CNT_W) - 1;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic [REG_W-1:0] id_rs_i = 5'd0;
    logic [REG_W-1:0] id_rt_i = 5'd0;
    logic [REG_W-1:0] id_rd_i = 5'd0;
    logic             id_regwrite_i = 1'b0;
    logic             id_memread_i = 1'b0;
    logic             ex_branch_tkn_i = 1'b0;
    logic [1:0]       fwd_a_sel_o;
    logic [1:0]       fwd_b_sel_o;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_flush_o;
`ifdef FWD_HAZ_STATS_EN
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
`endif

    fwd_hazard_ctrl #(
        .REG_W(REG_W)
`ifdef FWD_HAZ_STATS_EN
        , .CNT_W(CNT_W)
`endif
    ) u_dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .id_rs_i         (id_rs_i),
        .id_rt_i         (id_rt_i),
        .id_rd_i         (id_rd_i),
        .id_regwrite_i   (id_regwrite_i),
        .id_memread_i    (id_memread_i),
        .ex_branch_tkn_i (ex_branch_tkn_i),
        .fwd_a_sel_o     (fwd_a_sel_o),
        .fwd_b_sel_o     (fwd_b_sel_o),
        .pc_write_o      (pc_write_o),
        .ifid_write_o    (ifid_write_o),
        .ifid_flush_o    (ifid_flush_o),
        .idex_flush_o    (idex_flush_o)
`ifdef FWD_HAZ_STATS_EN
        ,
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // One in-flight instruction as the model sees it
    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    // inflight[0] is in EX, [1] in MEM, [2] in WB
    instr_t inflight[$];
    int n_checks = 0;
    int n_errors = 0;
    logic last_stall = 1'b0;
    logic last_flush = 1'b0;
    instr_t held;
`ifdef FWD_HAZ_STATS_EN
    int stall_total = 0;
    int flush_total = 0;
`endif

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        instr_t z;
        z = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
        inflight = {};
        for (int i = 0; i < 3; i++) inflight.push_back(z);
        last_stall = 1'b0;
        last_flush = 1'b0;
`ifdef FWD_HAZ_STATS_EN
        stall_total = 0;
        flush_total = 0;
`endif
    endtask

    // Most recent older producer of src wins; $0 never forwarded
    function automatic logic [1:0] exp_sel(input logic [4:0] src);
        for (int age = 1; age <= 2; age++) begin
            if (inflight[age].rw && inflight[age].rd != 5'd0 && inflight[age].rd == src)
                return (age == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    // Present one instruction in ID for one cycle; checks at the negedge
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic br);
        instr_t head;
        logic ldu;
        logic bubble;
        @(posedge clk_i);
        #1;
        id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
        id_regwrite_i = rw; id_memread_i = mr; ex_branch_tkn_i = br;
        @(negedge clk_i);
        head = inflight[0];
        ldu = head.mr && head.rd != 5'd0 && (head.rd == rs || head.rd == rt);
        bubble = br || ldu;
        chk("fwd_a", fwd_a_sel_o, exp_sel(head.rs));
        chk("fwd_b", fwd_b_sel_o, exp_sel(head.rt));
        chk("pc_write", pc_write_o, br || !ldu);
        chk("ifid_write", ifid_write_o, br || !ldu);
        chk("ifid_flush", ifid_flush_o, br);
        chk("idex_flush", idex_flush_o, bubble);
`ifdef FWD_HAZ_STATS_EN
        chk("stall_cnt", stall_cnt_o, (stall_total > CNT_SAT) ? CNT_SAT : stall_total);
        chk("flush_cnt", flush_cnt_o, (flush_total > CNT_SAT) ? CNT_SAT : flush_total);
        if (br) flush_total++;
        else if (ldu) stall_total++;
`endif
        held = '{rs, rt, rd, rw, mr};
        inflight.push_front('{rs, rt, rd, rw && !bubble, mr && !bubble});
        void'(inflight.pop_back());
        last_stall = !br && ldu;
        last_flush = br;
    endtask

    task automatic nop();
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [4:0] r_rs, r_rt, r_rd;
        logic r_rw, r_mr, r_br;

        // Reset state
        model_reset();
        #1;
        chk("rst_fwd_a", fwd_a_sel_o, 2'b00);
        chk("rst_fwd_b", fwd_b_sel_o, 2'b00);
        chk("rst_pc_write", pc_write_o, 1'b1);
        chk("rst_ifid_write", ifid_write_o, 1'b1);
        chk("rst_flushes", {ifid_flush_o, idex_flush_o}, 2'b00);
        #11;
        rst_i = 1'b1;

        // EX/MEM forward to rs
        step(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        step(5'd3, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
        nop();
        chk("t1_fwd_a", fwd_a_sel_o, 2'b10);
        chk("t1_fwd_b", fwd_b_sel_o, 2'b00);
        chk("t1_no_stall", pc_write_o, 1'b1);

        // MEM/WB forward, then EX/MEM priority over MEM/WB
        step(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        step(5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        step(5'd7, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        nop();
        chk("t2_fwd_a_wb", fwd_a_sel_o, 2'b01);
        step(5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
        step(5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
        step(5'd0, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0);
        nop();
        chk("t2_fwd_b_prio", fwd_b_sel_o, 2'b10);

        // Load-use on rt: one stall cycle, then MEM/WB forward
        step(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
        step(5'd0, 5'd4, 5'd12, 1'b1, 1'b0, 1'b0);
        chk("t3_stall_ctl", {pc_write_o, ifid_write_o, idex_flush_o, ifid_flush_o}, 4'b0010);
        step(5'd0, 5'd4, 5'd12, 1'b1, 1'b0, 1'b0);
        chk("t3_resume", pc_write_o, 1'b1);
        nop();
        chk("t3_fwd_b_wb", fwd_b_sel_o, 2'b01);

        // $0 is never forwarded and never stalls
        step(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        step(5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
        nop();
        chk("t4_zero_sel", {fwd_a_sel_o, fwd_b_sel_o}, 4'b0000);
        step(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        step(5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
        chk("t4_zero_nostall", pc_write_o, 1'b1);

        // Taken branch with a pending load-use: branch wins
        step(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        step(5'd5, 5'd0, 5'd15, 1'b1, 1'b0, 1'b1);
        chk("t5_br_ctl", {pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o}, 4'b1111);
        nop();
        nop();

        // Reset in the middle of a stall
        step(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0);
        step(5'd6, 5'd0, 5'd16, 1'b1, 1'b0, 1'b0);
        chk("t6_in_stall", pc_write_o, 1'b0);
        ex_branch_tkn_i = 1'b1;
        rst_i = 1'b0;
        #1;
        chk("t6_rst_ctl", {pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o}, 4'b1100);
        chk("t6_rst_sel", {fwd_a_sel_o, fwd_b_sel_o}, 4'b0000);
        model_reset();
        #2;
        ex_branch_tkn_i = 1'b0;
        rst_i = 1'b1;
        nop();
        chk("t6_post_sel", {fwd_a_sel_o, fwd_b_sel_o}, 4'b0000);

        // Five load-use stalls to saturate the stall counter
        for (int i = 0; i < 5; i++) begin
            step(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
            step(5'd4, 5'd0, 5'd17, 1'b1, 1'b0, 1'b0);
            step(5'd4, 5'd0, 5'd17, 1'b1, 1'b0, 1'b0);
        end
        nop();
`ifdef FWD_HAZ_STATS_EN
        chk("t6_stall_sat", stall_cnt_o, 2'd3);
        chk("t6_flush_cnt", flush_cnt_o, 2'd0);
`endif

        // Randomized instruction stream
        for (int i = 0; i < 400; i++) begin
            r_br = ($urandom_range(0, 7) == 0);
            if (last_stall) begin
                step(held.rs, held.rt, held.rd, held.rw, held.mr, r_br);
            end else if (last_flush) begin
                step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, r_br);
            end else begin
                r_rs = 5'($urandom_range(0, 7));
                r_rt = 5'($urandom_range(0, 7));
                r_rd = 5'($urandom_range(0, 7));
                r_rw = 1'($urandom_range(0, 1));
                r_mr = r_rw && ($urandom_range(0, 2) == 0);
                step(r_rs, r_rt, r_rd, r_rw, r_mr, r_br);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
